// File: rtl/vanilla_instr_encoder_if.sv
// Request/response bundle for the vanilla instruction encoder.
//
// Handshake semantics (both directions are strict valid/ready):
//   request : a request transfers on a cycle where v_i & ready_o are both high;
//             op/rd/rs1/rs2/imm are only meaningful on that cycle.
//   response: a word transfers on a cycle where v_o & yumi_i are both high;
//             yumi_i may only be raised while v_o is high, and instr_o/last_o
//             stay stable while v_o is high and yumi_i is low.
// ready_o may depend combinationally on yumi_i (back-to-back throughput).
interface vanilla_instr_encoder_if #(
    parameter int count_width_p = 16
);
    logic                     v_i;
    logic                     ready_o;
    logic [3:0]               op_i;
    logic [4:0]               rd_i;
    logic [4:0]               rs1_i;
    logic [4:0]               rs2_i;
    logic [31:0]              imm_i;
    logic                     v_o;
    logic                     yumi_i;
    logic [31:0]              instr_o;
    logic                     last_o;
    logic                     error_o;
    logic [count_width_p-1:0] count_o;
    logic [1:0]               state_o;   // debug view of the emit FSM

    modport slave (
        input  v_i, op_i, rd_i, rs1_i, rs2_i, imm_i, yumi_i,
        output ready_o, v_o, instr_o, last_o, error_o, count_o, state_o
    );

    modport master (
        output v_i, op_i, rd_i, rs1_i, rs2_i, imm_i, yumi_i,
        input  ready_o, v_o, instr_o, last_o, error_o, count_o, state_o
    );
endinterface

// File: rtl/vanilla_instr_encoder.sv
// Field-level request -> RV32IMA instruction word encoder.
// Expands LI into LUI(+ADDI), range-checks immediates, and streams words out
// with a last-word marker. One word is held at a time; the second LI word is
// parked in second_q until the first one is taken.
module vanilla_instr_encoder #(
    parameter bit nop_on_error_p = 1'b0,
    parameter bit amo_aq_p       = 1'b0,
    parameter bit amo_rl_p       = 1'b0,
    parameter int count_width_p  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    vanilla_instr_encoder_if.slave  bus
);

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [31:0] FENCE_WORD = 32'h0FF0_000F;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [31:0]              instr_q, instr_d;
    logic [31:0]              second_q, second_d;
    logic                     last_q, last_d;
    logic                     error_q, error_d;
    logic [count_width_p-1:0] count_q, count_d;

    logic        accept;
    logic        fire_out;
    logic        v_out;
    logic        ready;

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        in_i12;
    logic        in_b13;
    logic        in_j21;
    logic [31:0] li_hi;

    logic [31:0] enc_w1;
    logic [31:0] enc_w2;
    logic        enc_two;
    logic        enc_err;

    assign imm = bus.imm_i;
    assign rd  = bus.rd_i;
    assign rs1 = bus.rs1_i;
    assign rs2 = bus.rs2_i;

    // Signed immediate windows of the I/S, B and J formats.
    assign in_i12 = ($signed(imm) >= -32'sd2048)    && ($signed(imm) <= 32'sd2047);
    assign in_b13 = ($signed(imm) >= -32'sd4096)    && ($signed(imm) <= 32'sd4094)    && !imm[0];
    assign in_j21 = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];

    // Rounded upper part so that LUI hi + sign-extended imm[11:0] == imm.
    assign li_hi = imm + 32'h0000_0800;

    assign v_out    = (state_q != IDLE);
    assign fire_out = v_out && bus.yumi_i;
    assign ready    = (state_q == IDLE) || (v_out && last_q && bus.yumi_i);
    assign accept   = bus.v_i && ready;

    // Encode the presented request into one or two words plus an error flag.
    always_comb begin
        enc_w1  = NOP_WORD;
        enc_w2  = NOP_WORD;
        enc_two = 1'b0;
        enc_err = 1'b0;
        case (bus.op_i)
            4'd0: enc_w1 = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_OP};
            4'd1: begin
                enc_w1  = {imm[11:0], rs1, 3'b000, rd, OPC_OPIMM};
                enc_err = !in_i12;
            end
            4'd2: begin
                enc_w1  = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
                enc_err = !in_i12;
            end
            4'd3: begin
                enc_w1  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
                enc_err = !in_i12;
            end
            4'd4: begin
                enc_w1  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
                enc_err = !in_b13;
            end
            4'd5: begin
                enc_w1  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                enc_err = !in_j21;
            end
            4'd6: begin
                enc_w1  = {imm[19:0], rd, OPC_LUI};
                enc_err = (imm[31:20] != 12'd0);
            end
            4'd7: begin
                if (in_i12) begin
                    enc_w1 = {imm[11:0], 5'd0, 3'b000, rd, OPC_OPIMM};
                end else begin
                    enc_w1  = {li_hi[31:12], rd, OPC_LUI};
                    enc_w2  = {imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
                    enc_two = (imm[11:0] != 12'd0);
                end
            end
            4'd8:  enc_w1 = FENCE_WORD;
            4'd9:  enc_w1 = {7'b0000001, rs2, rs1, 3'b000, rd, OPC_OP};
            4'd10: enc_w1 = {5'b00000, amo_aq_p, amo_rl_p, rs2, rs1, 3'b010, rd, OPC_AMO};
            4'd11: enc_w1 = NOP_WORD;
            default: enc_err = 1'b1;
        endcase
    end

    // Next-state: advance the held word, then load a newly accepted request.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        second_d = second_q;
        last_d   = last_q;
        error_d  = 1'b0;
        count_d  = count_q;
        if (fire_out) begin
            count_d = count_q + 1'b1;
        end
        if ((state_q == EMIT1) && fire_out && !last_q) begin
            state_d = EMIT2;
            instr_d = second_q;
            last_d  = 1'b1;
        end else if ((state_q == IDLE) || (fire_out && last_q)) begin
            state_d = IDLE;
            last_d  = 1'b0;
            if (accept) begin
                if (enc_err) begin
                    error_d = 1'b1;
                    if (nop_on_error_p) begin
                        state_d = EMIT1;
                        instr_d = NOP_WORD;
                        last_d  = 1'b1;
                    end
                end else begin
                    state_d  = EMIT1;
                    instr_d  = enc_w1;
                    second_d = enc_w2;
                    last_d   = !enc_two;
                end
            end
        end
    end

    // Register all state; reset wins over any in-flight request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            instr_q  <= 32'd0;
            second_q <= 32'd0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            second_q <= second_d;
            last_q   <= last_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    assign bus.ready_o = ready;
    assign bus.v_o     = v_out;
    assign bus.instr_o = instr_q;
    assign bus.last_o  = last_q;
    assign bus.error_o = error_q;
    assign bus.count_o = count_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_vanilla_instr_encoder.sv
// Bench for vanilla_instr_encoder: directed spot checks plus randomized
// traffic scored against a field-arithmetic reference model. Two instances
// cover both error policies (drop vs NOP substitute) and both AMO bit settings.
module tb_vanilla_instr_encoder;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    // Shared request fields; v/yumi steered to the selected instance.
    int          sel = 0;
    logic        v_drv = 1'b0;
    logic        yumi_drv = 1'b0;
    logic [3:0]  op_r = 4'd0;
    logic [4:0]  rd_r = 5'd0;
    logic [4:0]  rs1_r = 5'd0;
    logic [4:0]  rs2_r = 5'd0;
    logic [31:0] imm_r = 32'd0;

    vanilla_instr_encoder_if #(.count_width_p(16)) if0 ();
    vanilla_instr_encoder_if #(.count_width_p(16)) if1 ();

    assign if0.v_i    = v_drv && (sel == 0);
    assign if1.v_i    = v_drv && (sel == 1);
    assign if0.yumi_i = yumi_drv && (sel == 0);
    assign if1.yumi_i = yumi_drv && (sel == 1);
    assign if0.op_i = op_r;   assign if1.op_i = op_r;
    assign if0.rd_i = rd_r;   assign if1.rd_i = rd_r;
    assign if0.rs1_i = rs1_r; assign if1.rs1_i = rs1_r;
    assign if0.rs2_i = rs2_r; assign if1.rs2_i = rs2_r;
    assign if0.imm_i = imm_r; assign if1.imm_i = imm_r;

    vanilla_instr_encoder #(
        .nop_on_error_p(1'b0), .amo_aq_p(1'b1), .amo_rl_p(1'b0), .count_width_p(16)
    ) u_dut0 (.clk_i(clk_i), .reset_i(reset_i), .bus(if0));

    vanilla_instr_encoder #(
        .nop_on_error_p(1'b1), .amo_aq_p(1'b0), .amo_rl_p(1'b1), .count_width_p(16)
    ) u_dut1 (.clk_i(clk_i), .reset_i(reset_i), .bus(if1));

    logic        cur_vo, cur_rdy, cur_last, cur_err;
    logic [31:0] cur_instr;
    logic [15:0] cur_cnt;
    assign cur_vo    = (sel == 0) ? if0.v_o     : if1.v_o;
    assign cur_rdy   = (sel == 0) ? if0.ready_o : if1.ready_o;
    assign cur_last  = (sel == 0) ? if0.last_o  : if1.last_o;
    assign cur_err   = (sel == 0) ? if0.error_o : if1.error_o;
    assign cur_instr = (sel == 0) ? if0.instr_o : if1.instr_o;
    assign cur_cnt   = (sel == 0) ? if0.count_o : if1.count_o;

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];     // {last, word} still owed by the DUT
    int          exp_cnt = 0;
    bit          exp_err = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    int bnd[16] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                    -1048576, -1048578, 1048574, 1048576, 0, 32'h000FFFFF,
                    32'h7FFFF800, 32'h80000000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] s2,
                                          input logic [31:0] s1, input logic [31:0] f3,
                                          input logic [31:0] d, input logic [31:0] opc);
        return (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] im, input logic [31:0] s1,
                                          input logic [31:0] f3, input logic [31:0] d,
                                          input logic [31:0] opc);
        return (bits(im, 11, 0) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] up, input logic [31:0] d);
        return (bits(up, 19, 0) << 12) | (d << 7) | 32'h37;
    endfunction

    // Compute the words/error the current request must produce and queue them.
    task automatic model_push();
        logic [31:0] w[$];
        logic [31:0] aq;
        logic [31:0] rl;
        logic [31:0] d, s1, s2;
        int          s;
        bit          err;
        s   = $signed(imm_r);
        d   = 32'(rd_r);
        s1  = 32'(rs1_r);
        s2  = 32'(rs2_r);
        aq  = (sel == 0) ? 32'd1 : 32'd0;
        rl  = (sel == 1) ? 32'd1 : 32'd0;
        err = 1'b0;
        case (op_r)
            4'd0: w.push_back(enc_r(0, s2, s1, 0, d, 32'h33));
            4'd1: if (s >= -2048 && s <= 2047) w.push_back(enc_i(imm_r, s1, 0, d, 32'h13)); else err = 1;
            4'd2: if (s >= -2048 && s <= 2047) w.push_back(enc_i(imm_r, s1, 2, d, 32'h03)); else err = 1;
            4'd3: if (s >= -2048 && s <= 2047)
                      w.push_back((bits(imm_r, 11, 5) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12) |
                                  (bits(imm_r, 4, 0) << 7) | 32'h23);
                  else err = 1;
            4'd4: if (s >= -4096 && s <= 4094 && (s % 2) == 0)
                      w.push_back((bits(imm_r, 12, 12) << 31) | (bits(imm_r, 10, 5) << 25) | (s2 << 20) |
                                  (s1 << 15) | (bits(imm_r, 4, 1) << 8) | (bits(imm_r, 11, 11) << 7) | 32'h63);
                  else err = 1;
            4'd5: if (s >= -1048576 && s <= 1048574 && (s % 2) == 0)
                      w.push_back((bits(imm_r, 20, 20) << 31) | (bits(imm_r, 10, 1) << 21) |
                                  (bits(imm_r, 11, 11) << 20) | (bits(imm_r, 19, 12) << 12) | (d << 7) | 32'h6F);
                  else err = 1;
            4'd6: if ((imm_r >> 20) == 0) w.push_back(enc_u(imm_r, d)); else err = 1;
            4'd7: begin
                if (s >= -2048 && s <= 2047) begin
                    w.push_back(enc_i(imm_r, 0, 0, d, 32'h13));
                end else begin
                    w.push_back(enc_u((imm_r + 32'h800) >> 12, d));
                    if ((imm_r & 32'hFFF) != 0) w.push_back(enc_i(imm_r, d, 0, d, 32'h13));
                end
            end
            4'd8:  w.push_back(32'h0FF0000F);
            4'd9:  w.push_back(enc_r(1, s2, s1, 0, d, 32'h33));
            4'd10: w.push_back(enc_r((aq << 1) | rl, s2, s1, 2, d, 32'h2F));
            4'd11: w.push_back(32'h00000013);
            default: err = 1;
        endcase
        if (err && sel == 1) w.push_back(32'h00000013);
        for (int i = 0; i < w.size(); i++) begin
            exp_q.push_back({(i == w.size() - 1) ? 1'b1 : 1'b0, w[i]});
        end
        exp_err = err;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        op_r = op; rd_r = rd; rs1_r = rs1; rs2_r = rs2; imm_r = imm;
    endtask

    task automatic rand_req();
        int kind;
        op_r  = 4'($urandom_range(0, 15));
        rd_r  = 5'($urandom_range(0, 31));
        rs1_r = 5'($urandom_range(0, 31));
        rs2_r = 5'($urandom_range(0, 31));
        kind  = $urandom_range(0, 5);
        case (kind)
            0: imm_r = $urandom_range(0, 4095) - 32'd2048;
            1: imm_r = $urandom_range(0, 8191) - 32'd4096;
            2: imm_r = $urandom;
            3: imm_r = bnd[$urandom_range(0, 15)];
            4: imm_r = $urandom_range(0, 32'h1FFFFF) - 32'h100000;
            default: imm_r = $urandom & 32'h000FFFFF;
        endcase
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit req, input bit take, output bit acc);
        bit exp_rdy;
        v_drv    = req;
        yumi_drv = take && (exp_q.size() != 0);
        #1;
        check("count", 32'(cur_cnt), exp_cnt & 32'hFFFF);
        check_b("error", cur_err, exp_err);
        exp_err = 1'b0;
        check_b("v_o", cur_vo, exp_q.size() != 0);
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && yumi_drv);
        check_b("ready", cur_rdy, exp_rdy);
        if (exp_q.size() != 0) begin
            check("instr", cur_instr, exp_q[0][31:0]);
            check_b("last", cur_last, exp_q[0][32]);
        end
        if (yumi_drv) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
        acc = req && cur_rdy;
        if (acc) model_push();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i  = 1'b1;
        v_drv    = 1'b0;
        yumi_drv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_b("rst_v_o", cur_vo, 1'b0);
        end
        check_b("rst_ready", cur_rdy, 1'b1);
        check("rst_count", 32'(cur_cnt), 32'd0);
        check_b("rst_error", cur_err, 1'b0);
        check_b("rst_last", cur_last, 1'b0);
        check("rst_instr", cur_instr, 32'd0);
        reset_i = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    task automatic rand_run(input int ncyc);
        bit have;
        bit acc;
        have = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                rand_req();
                have = 1'b1;
            end
            cycle(have, $urandom_range(0, 3) != 0, acc);
            if (acc) have = 1'b0;
        end
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle(1'b0, 1'b1, acc);
        check("drain", exp_q.size(), 32'd0);
        cycle(1'b0, 1'b0, acc);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit acc;
        sel = 0;
        do_reset();

        // ADDI x5, x0, -1
        set_req(4'd1, 5'd5, 5'd0, 5'd0, -32'sd1);
        cycle(1'b1, 1'b0, acc);
        check_b("addi_acc", acc, 1'b1);
        check("addi_word", cur_instr, 32'hFFF00293);
        check_b("addi_last", cur_last, 1'b1);
        cycle(1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, acc);
        check("addi_count", 32'(cur_cnt), 32'd1);

        // LI x10, 0x12345FFF with a 5-cycle stall on the first word
        set_req(4'd7, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        cycle(1'b1, 1'b0, acc);
        check("li2_w1", cur_instr, 32'h12346537);
        check_b("li2_last1", cur_last, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, acc);
        check("stall_instr", cur_instr, 32'h12346537);
        check_b("stall_ready", cur_rdy, 1'b0);
        cycle(1'b0, 1'b1, acc);
        check("li2_w2", cur_instr, 32'hFFF50513);
        check_b("li2_last2", cur_last, 1'b1);
        // reset while the second LI word is held
        do_reset();

        // LI x1, 0x1000 -> single LUI
        set_req(4'd7, 5'd1, 5'd0, 5'd0, 32'h00001000);
        cycle(1'b1, 1'b0, acc);
        check("li1_word", cur_instr, 32'h000010B7);
        check_b("li1_last", cur_last, 1'b1);
        cycle(1'b0, 1'b1, acc);

        // JAL x1, 2048
        set_req(4'd5, 5'd1, 5'd0, 5'd0, 32'd2048);
        cycle(1'b1, 1'b0, acc);
        check("jal_word", cur_instr, 32'h001000EF);
        cycle(1'b0, 1'b1, acc);

        // BEQ with odd offset: dropped, error pulse only
        set_req(4'd4, 5'd0, 5'd1, 5'd2, 32'd3);
        cycle(1'b1, 1'b0, acc);
        check_b("beq_err", cur_err, 1'b1);
        check_b("beq_no_v", cur_vo, 1'b0);
        cycle(1'b0, 1'b0, acc);

        // back-to-back single-word requests at full throughput
        for (int k = 0; k < 6; k++) begin
            set_req(4'd0, 5'(k + 1), 5'(k), 5'(k + 2), 32'd0);
            cycle(1'b1, 1'b1, acc);
            check_b("b2b_acc", acc, 1'b1);
        end
        drain();

        rand_run(600);
        drain();

        // NOP-on-error instance
        sel = 1;
        do_reset();
        set_req(4'd4, 5'd0, 5'd1, 5'd2, 32'd3);
        cycle(1'b1, 1'b0, acc);
        check_b("nop_v", cur_vo, 1'b1);
        check("nop_word", cur_instr, 32'h00000013);
        check_b("nop_last", cur_last, 1'b1);
        check_b("nop_err", cur_err, 1'b1);
        cycle(1'b0, 1'b1, acc);

        rand_run(400);
        drain();

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
